// File: rtl/yin_pkg.sv
// Shared YIN pitch-detector types and widths.
// Holds the lag/data widths used by the difference stage, the CMND picker
// FSM state encoding and the (d, tau, S) point payload used for ratio compares.
package yin_pkg;

  localparam int unsigned INTERMEDIATE_DATA_WIDTH = 64;
  localparam int unsigned TAU_WIDTH               = 6;
  localparam int unsigned MAX_TAU                 = 40;
  localparam int unsigned THRESH_WIDTH            = 8;
  localparam int unsigned SUM_WIDTH               = INTERMEDIATE_DATA_WIDTH + TAU_WIDTH;
  localparam int unsigned PROD_WIDTH              = 2 * SUM_WIDTH;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    DIP   = 2'd1,
    DRAIN = 2'd2
  } pick_state_e;

  // One lag of the CMND curve: d'(tau) = d * tau / s
  typedef struct packed {
    logic [INTERMEDIATE_DATA_WIDTH-1:0] d;
    logic [TAU_WIDTH-1:0]               tau;
    logic [SUM_WIDTH-1:0]               s;
  } cmnd_pt_t;

endpackage

// File: rtl/cmnd_ratio_cmp.sv
// Combinational d'(a) < d'(b) without division:
//   d(a)*a*S(b) < d(b)*b*S(a), evaluated at full product width.
// A point with S==0 is treated as d'=1.
// Ports: a, b (cmnd_pt_t points), lt_c (strict less-than of a versus b).
module cmnd_ratio_cmp
  import yin_pkg::*;
(
  input  cmnd_pt_t a,
  input  cmnd_pt_t b,
  output logic     lt_c
);

  logic [SUM_WIDTH-1:0] num_a, den_a, num_b, den_b;

  always_comb begin
    num_a = SUM_WIDTH'(a.d) * SUM_WIDTH'(a.tau);
    den_a = a.s;
    num_b = SUM_WIDTH'(b.d) * SUM_WIDTH'(b.tau);
    den_b = b.s;
    if (a.s == '0) begin
      num_a = SUM_WIDTH'(1);
      den_a = SUM_WIDTH'(1);
    end
    if (b.s == '0) begin
      num_b = SUM_WIDTH'(1);
      den_b = SUM_WIDTH'(1);
    end
    lt_c = (PROD_WIDTH'(num_a) * PROD_WIDTH'(den_b)) < (PROD_WIDTH'(num_b) * PROD_WIDTH'(den_a));
  end

endmodule

// File: rtl/cmnd_pitch_picker.sv
// YIN cumulative-mean-normalised difference and absolute-threshold pitch pick.
// Consumes d(1)..d(MAX_TAU) per frame and emits one lag estimate per frame.
// Optional macro CMND_GLOBAL_MIN_FALLBACK_EN: report the global-minimum lag
// when no frame dip crosses the threshold.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   diff_valid/tau/value  d(tau) sample stream, no backpressure
//   threshold             Q0.8 absolute threshold, captured with tau==1
//   pitch_valid           one-cycle result pulse with pitch_found/pitch_tau
//   seq_error             one-cycle pulse on a lag-sequence violation
module cmnd_pitch_picker #(
  parameter int unsigned MAX_TAU = yin_pkg::MAX_TAU
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        diff_valid,
  input  logic [yin_pkg::TAU_WIDTH-1:0]               diff_tau,
  input  logic [yin_pkg::INTERMEDIATE_DATA_WIDTH-1:0] diff_value,
  input  logic [yin_pkg::THRESH_WIDTH-1:0]            threshold,
  output logic                                        pitch_valid,
  output logic                                        pitch_found,
  output logic [yin_pkg::TAU_WIDTH-1:0]               pitch_tau,
  output logic                                        seq_error
);
  import yin_pkg::*;

  localparam int unsigned BT_WIDTH = SUM_WIDTH + THRESH_WIDTH;

  cmnd_pt_t                pt_q;
  logic [THRESH_WIDTH-1:0] thr_q;
  logic [TAU_WIDTH-1:0]    exp_q;
  logic                    active_q, vld_q, new_q, err_q;

  pick_state_e state_q, state_nxt, cur_state_c;
  cmnd_pt_t    min_q, min_nxt;

  logic                 pv_c, pf_c, se_c;
  logic [TAU_WIDTH-1:0] pt_c;

  logic [SUM_WIDTH-1:0] num_c;
  logic [BT_WIDTH-1:0]  lhs_c, rhs_c;
  logic                 below_c, last_c, dip_lt_c;

  // Accept stage: sequence check and running sum S
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pt_q     <= '0;
      thr_q    <= '0;
      exp_q    <= TAU_WIDTH'(1);
      active_q <= 1'b0;
      vld_q    <= 1'b0;
      new_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      new_q <= 1'b0;
      err_q <= 1'b0;
      if (diff_valid) begin
        if (diff_tau == TAU_WIDTH'(1)) begin
          pt_q.d   <= diff_value;
          pt_q.tau <= diff_tau;
          pt_q.s   <= SUM_WIDTH'(diff_value);
          thr_q    <= threshold;
          exp_q    <= TAU_WIDTH'(2);
          active_q <= 1'b1;
          vld_q    <= 1'b1;
          new_q    <= 1'b1;
        end else if (active_q) begin
          if (diff_tau == exp_q) begin
            pt_q.d   <= diff_value;
            pt_q.tau <= diff_tau;
            pt_q.s   <= pt_q.s + SUM_WIDTH'(diff_value);
            exp_q    <= exp_q + TAU_WIDTH'(1);
            active_q <= (diff_tau != TAU_WIDTH'(MAX_TAU));
            vld_q    <= 1'b1;
          end else begin
            err_q    <= 1'b1;
            active_q <= 1'b0;
          end
        end
      end
    end
  end

  // Threshold test: d*tau*2^THRESH_WIDTH < threshold*S, false when S==0
  always_comb begin
    num_c   = SUM_WIDTH'(pt_q.d) * SUM_WIDTH'(pt_q.tau);
    lhs_c   = BT_WIDTH'(num_c) << THRESH_WIDTH;
    rhs_c   = BT_WIDTH'(thr_q) * BT_WIDTH'(pt_q.s);
    below_c = (pt_q.s != '0) && (lhs_c < rhs_c);
    last_c  = (pt_q.tau == TAU_WIDTH'(MAX_TAU));
  end

  cmnd_ratio_cmp u_dip_cmp (
    .a    (pt_q),
    .b    (min_q),
    .lt_c (dip_lt_c)
  );

`ifdef CMND_GLOBAL_MIN_FALLBACK_EN
  cmnd_pt_t gmin_q, gmin_nxt;
  logic     g_lt_c, g_take_c;

  cmnd_ratio_cmp u_gmin_cmp (
    .a    (pt_q),
    .b    (gmin_q),
    .lt_c (g_lt_c)
  );

  // First lag of a frame always seeds the global minimum; ties keep the earlier lag
  always_comb g_take_c = new_q || g_lt_c;
`endif

  // Next-state and result decode
  always_comb begin
    state_nxt   = state_q;
    min_nxt     = min_q;
    pv_c        = 1'b0;
    pf_c        = 1'b0;
    pt_c        = '0;
    se_c        = 1'b0;
    cur_state_c = new_q ? SCAN : state_q;
`ifdef CMND_GLOBAL_MIN_FALLBACK_EN
    gmin_nxt    = gmin_q;
`endif
    if (err_q) begin
      se_c      = (state_q != DRAIN);
      state_nxt = DRAIN;
    end else if (vld_q) begin
      state_nxt = cur_state_c;
      case (cur_state_c)
        SCAN: begin
`ifdef CMND_GLOBAL_MIN_FALLBACK_EN
          if (g_take_c) gmin_nxt = pt_q;
`endif
          if (below_c) begin
            min_nxt   = pt_q;
            state_nxt = DIP;
            if (last_c) begin
              pv_c      = 1'b1;
              pf_c      = 1'b1;
              pt_c      = pt_q.tau;
              state_nxt = DRAIN;
            end
          end else if (last_c) begin
            pv_c = 1'b1;
`ifdef CMND_GLOBAL_MIN_FALLBACK_EN
            pt_c = g_take_c ? pt_q.tau : gmin_q.tau;
`endif
            state_nxt = SCAN;
          end
        end
        DIP: begin
          if (dip_lt_c) begin
            min_nxt = pt_q;
            if (last_c) begin
              pv_c      = 1'b1;
              pf_c      = 1'b1;
              pt_c      = pt_q.tau;
              state_nxt = DRAIN;
            end
          end else begin
            pv_c      = 1'b1;
            pf_c      = 1'b1;
            pt_c      = min_q.tau;
            state_nxt = DRAIN;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state and stored minima
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCAN;
      min_q   <= '0;
`ifdef CMND_GLOBAL_MIN_FALLBACK_EN
      gmin_q  <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      min_q   <= min_nxt;
`ifdef CMND_GLOBAL_MIN_FALLBACK_EN
      gmin_q  <= gmin_nxt;
`endif
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pitch_valid <= 1'b0;
      pitch_found <= 1'b0;
      pitch_tau   <= '0;
      seq_error   <= 1'b0;
    end else begin
      pitch_valid <= pv_c;
      pitch_found <= pf_c;
      pitch_tau   <= pt_c;
      seq_error   <= se_c;
    end
  end

endmodule

// File: tb/tb_cmnd_pitch_picker.sv
// Directed self-checking bench for cmnd_pitch_picker with MAX_TAU=8, threshold=0.25.
module tb_cmnd_pitch_picker;

  localparam int unsigned MT = 8;
`ifdef CMND_GLOBAL_MIN_FALLBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        diff_valid;
  logic [5:0]  diff_tau;
  logic [63:0] diff_value;
  logic [7:0]  threshold;
  logic        pitch_valid, pitch_found, seq_error;
  logic [5:0]  pitch_tau;

  always #5 clk = ~clk;

  cmnd_pitch_picker #(.MAX_TAU(MT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .diff_valid  (diff_valid),
    .diff_tau    (diff_tau),
    .diff_value  (diff_value),
    .threshold   (threshold),
    .pitch_valid (pitch_valid),
    .pitch_found (pitch_found),
    .pitch_tau   (pitch_tau),
    .seq_error   (seq_error)
  );

  int         cyc = 0;
  int         pv_cnt, se_cnt, pv_cyc;
  logic       pv_found;
  logic [5:0] pv_tau;
  int         dcyc [1:8];
  int         n_assert = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture result and error pulses at the falling edge
  always @(negedge clk) begin
    if (pitch_valid) begin
      pv_cnt++;
      pv_found = pitch_found;
      pv_tau   = pitch_tau;
      pv_cyc   = cyc;
    end
    if (seq_error) se_cnt++;
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear();
    pv_cnt = 0;
    se_cnt = 0;
    pv_cyc = -1;
    pv_found = 1'b0;
    pv_tau = '0;
  endtask

  task automatic send(input int t, input longint unsigned d);
    @(negedge clk);
    diff_valid = 1'b1;
    diff_tau   = 6'(t);
    diff_value = d;
    if (t >= 1 && t <= 8) dcyc[t] = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      diff_valid = 1'b0;
    end
  endtask

  task automatic frame(input longint unsigned dv [8]);
    for (int i = 0; i < 8; i++) send(i + 1, dv[i]);
    idle(4);
  endtask

  initial begin
    reset_n    = 1'b0;
    diff_valid = 1'b0;
    diff_tau   = '0;
    diff_value = '0;
    threshold  = 8'd64;
    clear();
    repeat (2) @(negedge clk);
    chk("reset_pitch_valid", longint'(pitch_valid), 0);
    chk("reset_pitch_found", longint'(pitch_found), 0);
    chk("reset_pitch_tau",   longint'(pitch_tau),   0);
    chk("reset_seq_error",   longint'(seq_error),   0);
    reset_n = 1'b1;
    idle(2);

    // Dip at tau 4, minimum at tau 5, ends at tau 6
    clear();
    frame('{100, 100, 100, 10, 5, 20, 100, 100});
    chk("dip_count", pv_cnt, 1);
    chk("dip_found", longint'(pv_found), 1);
    chk("dip_tau",   longint'(pv_tau), 5);
    chk("dip_cycle", pv_cyc, dcyc[6] + 2);
    chk("dip_seqerr", se_cnt, 0);

    // Flat curve: no dip, d'=1 everywhere
    clear();
    frame('{100, 100, 100, 100, 100, 100, 100, 100});
    chk("flat_count", pv_cnt, 1);
    chk("flat_found", longint'(pv_found), 0);
    chk("flat_tau",   longint'(pv_tau), FB ? 1 : 0);
    chk("flat_cycle", pv_cyc, dcyc[8] + 2);

    // Shallow valley at tau 4 never crosses threshold
    clear();
    frame('{100, 100, 100, 60, 60, 60, 60, 60});
    chk("valley_count", pv_cnt, 1);
    chk("valley_found", longint'(pv_found), 0);
    chk("valley_tau",   longint'(pv_tau), FB ? 4 : 0);

    // Still descending on the last lag
    clear();
    frame('{100, 100, 100, 100, 100, 100, 10, 2});
    chk("desc_count", pv_cnt, 1);
    chk("desc_found", longint'(pv_found), 1);
    chk("desc_tau",   longint'(pv_tau), 8);
    chk("desc_cycle", pv_cyc, dcyc[8] + 2);

    // Lag sequence 1,2,4
    clear();
    send(1, 100);
    send(2, 100);
    send(4, 100);
    send(5, 100);
    idle(4);
    chk("seq_err_count", se_cnt, 1);
    chk("seq_no_result", pv_cnt, 0);
    clear();
    frame('{100, 100, 100, 10, 5, 20, 100, 100});
    chk("seq_recover_count", pv_cnt, 1);
    chk("seq_recover_tau",   longint'(pv_tau), 5);
    chk("seq_recover_err",   se_cnt, 0);

    // tau==1 mid-frame restarts silently
    clear();
    send(1, 100);
    send(2, 100);
    send(3, 100);
    frame('{100, 100, 100, 10, 5, 20, 100, 100});
    chk("abort_count", pv_cnt, 1);
    chk("abort_tau",   longint'(pv_tau), 5);
    chk("abort_err",   se_cnt, 0);

    // Reset mid-frame discards the frame
    clear();
    send(1, 100);
    send(2, 100);
    send(3, 100);
    send(4, 10);
    @(negedge clk);
    diff_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("midrst_pitch_valid", longint'(pitch_valid), 0);
    chk("midrst_pitch_found", longint'(pitch_found), 0);
    chk("midrst_pitch_tau",   longint'(pitch_tau),   0);
    chk("midrst_seq_error",   longint'(seq_error),   0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);
    chk("midrst_no_result", pv_cnt, 0);
    clear();
    frame('{100, 100, 100, 10, 5, 20, 100, 100});
    chk("replay_count", pv_cnt, 1);
    chk("replay_found", longint'(pv_found), 1);
    chk("replay_tau",   longint'(pv_tau), 5);

    // All-zero difference: S==0 must not produce a dip
    clear();
    frame('{0, 0, 0, 0, 0, 0, 0, 0});
    chk("zero_count", pv_cnt, 1);
    chk("zero_found", longint'(pv_found), 0);
    chk("zero_tau",   longint'(pv_tau), FB ? 1 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
